// File: rtl/sig_chk_pkg.sv
// Shared types and helpers for the output signature checker.
package sig_chk_pkg;
  typedef enum logic [1:0] {IDLE, RUN, CMP} state_e;

  localparam logic [31:0] POLY_DEF   = 32'h04C11DB7;
  localparam logic [31:0] SEED_DEF   = 32'hFFFFFFFF;
  localparam int          FOLD_MAX_W = 1024;
  localparam int          SIG_MAX_W  = 64;

  // Bit i of the zero-padded vector lands in result bit (i mod sig_w).
  // This XORs all sig_w-wide chunks together. sig_w is constant at every
  // call site, so the whole loop reduces to a fixed XOR tree.
  function automatic logic [SIG_MAX_W-1:0] fold_xor(input logic [FOLD_MAX_W-1:0] d,
                                                    input int sig_w);
    logic [SIG_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < FOLD_MAX_W; i++)
      r[6'(i % sig_w)] = r[6'(i % sig_w)] ^ d[10'(i)];
    return r;
  endfunction
endpackage

// File: rtl/out_signature_checker_if.sv
// Sample stream into the signature checker: valid/ready handshake plus data.
interface out_signature_checker_if #(parameter int DATA_W = 330);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/sig_misr.sv
// Folds one data word into SIG_W bits and performs one MISR step per enabled cycle.
module sig_misr
  import sig_chk_pkg::*;
#(
  parameter int              DATA_W = 330,
  parameter int              SIG_W  = 32,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEF),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(SEED_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] data,
  output logic [SIG_W-1:0]  sig,
  output logic [SIG_W-1:0]  sig_nxt
);
  logic [SIG_W-1:0] f;
  logic [SIG_W-1:0] stepped;

  always_comb begin
    f       = SIG_W'(fold_xor(FOLD_MAX_W'(data), SIG_W));
    stepped = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ f;
    sig_nxt = load ? SEED : (step ? stepped : sig);
  end

  always_ff @(posedge clk) begin
    if (rst) sig <= SEED;
    else     sig <= sig_nxt;
  end
endmodule

// File: rtl/out_signature_checker.sv
// Compacts an output-vector stream into a MISR signature and compares it with a golden value.
// Optional lockstep compare against a reference stream: define SIG_LOCKSTEP_EN.
module out_signature_checker
  import sig_chk_pkg::*;
#(
  parameter int               DATA_W = 330,
  parameter int               SIG_W  = 32,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(POLY_DEF),
  parameter logic [SIG_W-1:0] SEED   = SIG_W'(SEED_DEF),
  parameter int               CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        n_samples,
  input  logic [SIG_W-1:0]        golden_sig,
  out_signature_checker_if.slave  bus,
`ifdef SIG_LOCKSTEP_EN
  input  logic [DATA_W-1:0]       ref_data,
  output logic                    mismatch,
  output logic [CNT_W-1:0]        first_mis_idx,
`endif
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [SIG_W-1:0]        signature,
  output logic [CNT_W-1:0]        sample_cnt
);
  state_e           state;
  logic             ready_q;
  logic [CNT_W-1:0] n_lat;
  logic [SIG_W-1:0] golden;
  logic [CNT_W-1:0] cnt_inc;
  logic [SIG_W-1:0] sig_nxt;
  logic             accept;
  logic             lock_ok;

  // A same-cycle start takes priority, so that sample is dropped.
  assign accept       = bus.in_valid & ready_q & ~start;
  assign bus.in_ready = ready_q;
  assign cnt_inc      = sample_cnt + CNT_W'(1);

`ifdef SIG_LOCKSTEP_EN
  logic mis_hit;
  assign mis_hit = accept & (bus.in_data != ref_data);
  assign lock_ok = ~(mismatch | mis_hit);
`else
  assign lock_ok = 1'b1;
`endif

  sig_misr #(
    .DATA_W (DATA_W),
    .SIG_W  (SIG_W),
    .POLY   (POLY),
    .SEED   (SEED)
  ) u_misr (
    .clk     (clk),
    .rst     (rst),
    .load    (start),
    .step    (accept),
    .data    (bus.in_data),
    .sig     (signature),
    .sig_nxt (sig_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ready_q    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      sample_cnt <= '0;
      n_lat      <= '0;
      golden     <= '0;
`ifdef SIG_LOCKSTEP_EN
      mismatch      <= 1'b0;
      first_mis_idx <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (start) begin
        n_lat      <= n_samples;
        golden     <= golden_sig;
        sample_cnt <= '0;
        busy       <= 1'b1;
`ifdef SIG_LOCKSTEP_EN
        mismatch      <= 1'b0;
        first_mis_idx <= '0;
`endif
        if (n_samples == '0) begin
          state   <= CMP;
          ready_q <= 1'b0;
          done    <= 1'b1;
          pass    <= (sig_nxt == golden_sig);
        end else begin
          state   <= RUN;
          ready_q <= 1'b1;
          pass    <= 1'b0;
        end
      end else begin
        case (state)
          RUN: if (accept) begin
            sample_cnt <= cnt_inc;
`ifdef SIG_LOCKSTEP_EN
            if (mis_hit && !mismatch) begin
              mismatch      <= 1'b1;
              first_mis_idx <= sample_cnt;
            end
`endif
            if (cnt_inc == n_lat) begin
              state   <= CMP;
              ready_q <= 1'b0;
              done    <= 1'b1;
              pass    <= (sig_nxt == golden) & lock_ok;
            end
          end
          CMP: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          IDLE: ;
          default: begin
            state   <= IDLE;
            ready_q <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_out_signature_checker.sv
// Directed bench for out_signature_checker; build with SIG_LOCKSTEP_EN to cover the lockstep path.
module tb_out_signature_checker;
  localparam int DATA_W = 330;
  localparam int SIG_W  = 32;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CNT_W-1:0]  n_samples;
  logic [SIG_W-1:0]  golden_sig;
  logic              busy, done, pass;
  logic [SIG_W-1:0]  signature;
  logic [CNT_W-1:0]  sample_cnt;
  logic [DATA_W-1:0] ref_d;
`ifdef SIG_LOCKSTEP_EN
  logic              mismatch;
  logic [CNT_W-1:0]  first_mis_idx;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  out_signature_checker_if #(.DATA_W(DATA_W)) bus ();

  out_signature_checker #(.DATA_W(DATA_W), .SIG_W(SIG_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .n_samples     (n_samples),
    .golden_sig    (golden_sig),
    .bus           (bus.slave),
`ifdef SIG_LOCKSTEP_EN
    .ref_data      (ref_d),
    .mismatch      (mismatch),
    .first_mis_idx (first_mis_idx),
`endif
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .signature     (signature),
    .sample_cnt    (sample_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input logic [DATA_W-1:0] d);
    bus.in_data = d;
    ref_d       = d;
  endtask

  task automatic kick(input logic [CNT_W-1:0] n, input logic [SIG_W-1:0] g);
    start = 1'b1; n_samples = n; golden_sig = g;
    tick();
    start = 1'b0;
  endtask

  task automatic run1(input string tag, input logic [DATA_W-1:0] d,
                      input logic [SIG_W-1:0] g, input logic [SIG_W-1:0] es, input logic ep);
    kick(1, g);
    bus.in_valid = 1'b1; set_data(d);
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "_done"}, 64'(done), 64'(1));
    chk({tag, "_sig"},  64'(signature), 64'(es));
    chk({tag, "_pass"}, 64'(pass), 64'(ep));
    tick();
    chk({tag, "_hold"}, 64'(pass), 64'(ep));
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    int dc;
    rst = 1'b1; start = 1'b0; n_samples = '0; golden_sig = '0;
    bus.in_valid = 1'b0; set_data('0);
    tick(); tick();
    rst = 1'b0;
    chk("rst_sig",   64'(signature), 64'h0FFFFFFFF);
    chk("rst_cnt",   64'(sample_cnt), 64'(0));
    chk("rst_ready", 64'(bus.in_ready), 64'(0));
    chk("rst_busy",  64'(busy), 64'(0));
    chk("rst_done",  64'(done), 64'(0));
    chk("rst_pass",  64'(pass), 64'(0));

    // n_samples == 0: compare the seed directly
    kick(0, 32'hFFFFFFFF);
    chk("n0_done",  64'(done), 64'(1));
    chk("n0_pass",  64'(pass), 64'(1));
    chk("n0_sig",   64'(signature), 64'h0FFFFFFFF);
    chk("n0_ready", 64'(bus.in_ready), 64'(0));
    tick();
    chk("n0_done_off", 64'(done), 64'(0));
    chk("n0_busy_off", 64'(busy), 64'(0));

    run1("z_pass", '0, 32'hFB3EE249, 32'hFB3EE249, 1'b1);
    run1("z_fail", '0, 32'h00000000, 32'hFB3EE249, 1'b0);
    d = '0; d[0] = 1'b1;
    run1("b0", d, 32'hFB3EE248, 32'hFB3EE248, 1'b1);
    d = '0; d[32] = 1'b1;
    run1("b32", d, 32'hFB3EE248, 32'hFB3EE248, 1'b1);
    d = '0; d[329] = 1'b1;
    run1("b329", d, 32'hFB3EE049, 32'hFB3EE049, 1'b1);

    // n=4 with in_valid toggling: accepts on even cycles only
    set_data('0);
    dc = done_cnt;
    kick(4, 32'hC7B0424D);
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = (i % 2 == 0);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("n4_cnt",   64'(sample_cnt), 64'(4));
    chk("n4_sig",   64'(signature), 64'hC7B0424D);
    chk("n4_pass",  64'(pass), 64'(1));
    chk("n4_dones", 64'(done_cnt - dc), 64'(1));
    bus.in_valid = 1'b1;
    repeat (5) tick();
    bus.in_valid = 1'b0;
    chk("idle_cnt",   64'(sample_cnt), 64'(4));
    chk("idle_sig",   64'(signature), 64'hC7B0424D);
    chk("idle_dones", 64'(done_cnt - dc), 64'(1));

    // restart at sample 2, start beating a same-cycle accept
    kick(4, 32'h0);
    bus.in_valid = 1'b1;
    tick(); tick();
    chk("rs_cnt2", 64'(sample_cnt), 64'(2));
    chk("rs_sig2", 64'(signature), 64'hF2BCD925);
    start = 1'b1; n_samples = 1; golden_sig = 32'hFB3EE249;
    tick();
    start = 1'b0;
    chk("rs_cnt0",  64'(sample_cnt), 64'(0));
    chk("rs_seed",  64'(signature), 64'h0FFFFFFFF);
    chk("rs_ready", 64'(bus.in_ready), 64'(1));
    tick();
    bus.in_valid = 1'b0;
    chk("rs_done", 64'(done), 64'(1));
    chk("rs_sig",  64'(signature), 64'hFB3EE249);
    chk("rs_pass", 64'(pass), 64'(1));
    tick();

    // rst at sample 2: back to reset values, no done
    kick(4, 32'h0);
    bus.in_valid = 1'b1;
    tick(); tick();
    dc = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_sig",   64'(signature), 64'h0FFFFFFFF);
    chk("mr_cnt",   64'(sample_cnt), 64'(0));
    chk("mr_busy",  64'(busy), 64'(0));
    chk("mr_ready", 64'(bus.in_ready), 64'(0));
    chk("mr_pass",  64'(pass), 64'(0));
    repeat (3) tick();
    bus.in_valid = 1'b0;
    chk("mr_cnt_idle", 64'(sample_cnt), 64'(0));
    chk("mr_nodone",   64'(done_cnt - dc), 64'(0));

    // n=6 zero samples; lockstep build corrupts the reference at sample 3
    kick(6, 32'h13822FED);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_data('0);
      if (i == 3) ref_d[5] = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    set_data('0);
    chk("n6_done", 64'(done), 64'(1));
    chk("n6_sig",  64'(signature), 64'h13822FED);
`ifdef SIG_LOCKSTEP_EN
    chk("ls_mis",  64'(mismatch), 64'(1));
    chk("ls_idx",  64'(first_mis_idx), 64'(3));
    chk("ls_pass", 64'(pass), 64'(0));
    tick();
    kick(0, 32'hFFFFFFFF);
    chk("ls_clr",  64'(mismatch), 64'(0));
    chk("ls_pass0", 64'(pass), 64'(1));
`else
    chk("n6_pass", 64'(pass), 64'(1));
`endif
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
